// File: rtl/phy_pkg.sv
// Shared PHY lane constants: symbol values, default widths and the aligner state encoding.
package phy_pkg;

  localparam int SYM_W_DEF  = 8;
  localparam int WORD_W_DEF = 32;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] IDL_SYM = 8'h7C;

  typedef logic [0:0] lane_state_t;
  typedef logic [1:0] slot_idx_t;

  localparam lane_state_t HUNT   = 1'b0;
  localparam lane_state_t LOCKED = 1'b1;

endpackage

// File: rtl/word_packer.sv
// Four-slot pack register; slot 0 lands in the most significant byte of the word.
module word_packer
  import phy_pkg::*;
#(
  parameter int SYM_W  = SYM_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic [SYM_W-1:0]  sym,
  input  slot_idx_t         byte_idx,
  input  logic              load,
  input  logic              clear,
  output logic              full,
  output logic [WORD_W-1:0] packed_word
);

  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] pack_d;

  always_comb begin
    pack_d = pack_q;
    if (load) begin
      case (byte_idx)
        2'd0:    pack_d[4*SYM_W-1 -: SYM_W] = sym;
        2'd1:    pack_d[3*SYM_W-1 -: SYM_W] = sym;
        2'd2:    pack_d[2*SYM_W-1 -: SYM_W] = sym;
        default: pack_d[SYM_W-1   -: SYM_W] = sym;
      endcase
    end
  end

  assign full        = load && (byte_idx == 2'd3);
  assign packed_word = pack_d;

  // Register restarts empty after a completed word or a discard.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L)          pack_q <= '0;
    else if (clear || full) pack_q <= '0;
    else                   pack_q <= pack_d;
  end

endmodule

// File: rtl/lane_word_aligner.sv
// Per-lane COM lock FSM and word assembly feeding the lane un-striper.
//  state  | meaning
//  HUNT   | searching for LOCK_COUNT consecutive COMs, nothing packed
//  LOCKED | packing data symbols into words, watching for loss of valid
module lane_word_aligner
  import phy_pkg::*;
#(
  parameter int               SYM_W      = SYM_W_DEF,
  parameter int               WORD_W     = WORD_W_DEF,
  parameter logic [SYM_W-1:0] COM        = COM_SYM,
  parameter logic [SYM_W-1:0] IDL        = IDL_SYM,
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 4
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              active,
  output logic              align_err
);

  localparam int CNT_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] LOSS_C = CW'(LOSS_COUNT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  lane_state_t   state_q, state_d;
  logic [CW-1:0] com_cnt_q, com_cnt_d;
  logic [CW-1:0] loss_cnt_q, loss_cnt_d;
  slot_idx_t     byte_idx_q, byte_idx_d;
  logic          load, clear, err_d, full;
  logic [WORD_W-1:0] packed_word;

  always_comb begin
    state_d    = state_q;
    com_cnt_d  = com_cnt_q;
    loss_cnt_d = loss_cnt_q;
    byte_idx_d = byte_idx_q;
    load       = 1'b0;
    clear      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      HUNT: begin
        loss_cnt_d = '0;
        byte_idx_d = '0;
        clear      = 1'b1;
        if (sym_valid && sym_in == COM) begin
          if (com_cnt_q < LOCK_C)          com_cnt_d = com_cnt_q + ONE_C;
          if (com_cnt_q >= LOCK_C - ONE_C) state_d   = LOCKED;
        end else begin
          com_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (!sym_valid) begin
          if (loss_cnt_q < LOSS_C) loss_cnt_d = loss_cnt_q + ONE_C;
          if (loss_cnt_q >= LOSS_C - ONE_C) begin
            state_d    = HUNT;
            com_cnt_d  = '0;
            loss_cnt_d = '0;
            byte_idx_d = '0;
            clear      = 1'b1;
            err_d      = (byte_idx_q != 2'd0);
          end
        end else begin
          loss_cnt_d = '0;
          if (sym_in == COM) begin
            // A COM inside a word means we were misaligned; restart the word.
            err_d      = (byte_idx_q != 2'd0);
            byte_idx_d = '0;
            clear      = 1'b1;
          end else if (sym_in != IDL) begin
            load       = 1'b1;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  word_packer #(
    .SYM_W (SYM_W),
    .WORD_W(WORD_W)
  ) u_packer (
    .clk_4f     (clk_4f),
    .reset_L    (reset_L),
    .sym        (sym_in),
    .byte_idx   (byte_idx_q),
    .load       (load),
    .clear      (clear),
    .full       (full),
    .packed_word(packed_word)
  );

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= HUNT;
      com_cnt_q  <= '0;
      loss_cnt_q <= '0;
      byte_idx_q <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      active     <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      com_cnt_q  <= com_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_out   <= full ? packed_word : '0;
      word_valid <= full;
      active     <= (state_d == LOCKED);
      align_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_lane_word_aligner.sv
// Randomized and directed bench for lane_word_aligner against a queue-based lane model.
module tb_lane_word_aligner;

  logic        clk_4f = 1'b0;
  logic        reset_L = 1'b0;
  logic [7:0]  sym_in = 8'h00;
  logic        sym_valid = 1'b0;
  logic [31:0] word_out;
  logic        word_valid, active, align_err;

  int checks = 0;
  int errors = 0;

  // Model state: lock flag, run lengths and the bytes collected for the current word.
  bit         m_locked;
  int         m_com_run, m_loss_run;
  logic [7:0] m_bytes[$];
  logic [31:0] e_word;
  logic        e_wv, e_act, e_err;

  always #5 clk_4f = ~clk_4f;

  lane_word_aligner dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .active    (active),
    .align_err (align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_com_run = 0; m_loss_run = 0; m_bytes.delete();
    e_word = '0; e_wv = 0; e_act = 0; e_err = 0;
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] s);
    e_wv = 0; e_word = '0; e_err = 0;
    if (!m_locked) begin
      m_bytes.delete();
      if (v && s == 8'hBC) begin
        m_com_run++;
        if (m_com_run >= 4) m_locked = 1;
      end else m_com_run = 0;
    end else if (!v) begin
      m_loss_run++;
      if (m_loss_run >= 4) begin
        m_locked = 0; m_com_run = 0; m_loss_run = 0;
        e_err = (m_bytes.size() != 0);
        m_bytes.delete();
      end
    end else begin
      m_loss_run = 0;
      if (s == 8'hBC) begin
        e_err = (m_bytes.size() != 0);
        m_bytes.delete();
      end else if (s != 8'h7C) begin
        m_bytes.push_back(s);
        if (m_bytes.size() == 4) begin
          e_wv = 1;
          e_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete();
        end
      end
    end
    e_act = m_locked;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".word_valid"}, {31'd0, word_valid}, {31'd0, e_wv});
    chk({tag, ".word_out"},   word_out, e_word);
    chk({tag, ".active"},     {31'd0, active}, {31'd0, e_act});
    chk({tag, ".align_err"},  {31'd0, align_err}, {31'd0, e_err});
  endtask

  task automatic step(input logic v, input logic [7:0] s, input string tag);
    @(negedge clk_4f);
    sym_valid = v;
    sym_in    = s;
    @(posedge clk_4f);
    model_cycle(v, s);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk_4f);
    reset_L = 1'b0; sym_valid = 1'b0; sym_in = 8'h00;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk_4f);
    reset_L = 1'b1;
  endtask

  task automatic send_lock();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hBC, "lock");
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] d;
    do d = 8'($urandom_range(0, 255)); while (d == 8'hBC || d == 8'h7C);
    return d;
  endfunction

  initial begin
    model_reset();
    #2;
    check_outputs("por");
    do_reset();

    // 1: lock on four COMs
    for (int i = 0; i < 3; i++) step(1'b1, 8'hBC, "t1_com");
    chk("t1_active_before", {31'd0, active}, 32'd0);
    step(1'b1, 8'hBC, "t1_com4");
    chk("t1_active_after", {31'd0, active}, 32'd1);

    // 2: plain word
    step(1'b1, 8'h11, "t2"); step(1'b1, 8'h22, "t2"); step(1'b1, 8'h33, "t2");
    step(1'b1, 8'h44, "t2_last");
    chk("t2_word", word_out, 32'h11223344);

    // 3: IDL skipped mid-word
    step(1'b1, 8'h11, "t3"); step(1'b1, 8'h7C, "t3_idl"); step(1'b1, 8'h22, "t3");
    step(1'b1, 8'h33, "t3"); step(1'b1, 8'h44, "t3_last");
    chk("t3_word", word_out, 32'h11223344);

    // 4: realign on COM inside a word
    step(1'b1, 8'hAA, "t4"); step(1'b1, 8'hBB, "t4"); step(1'b1, 8'hBC, "t4_com");
    chk("t4_align_err", {31'd0, align_err}, 32'd1);
    step(1'b1, 8'h01, "t4"); step(1'b1, 8'h02, "t4"); step(1'b1, 8'h03, "t4");
    step(1'b1, 8'h04, "t4_last");
    chk("t4_word", word_out, 32'h01020304);

    // 5: loss of lock with a partial word pending, then data ignored
    step(1'b1, 8'h55, "t5_partial");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, "t5_loss");
    chk("t5_active", {31'd0, active}, 32'd0);
    chk("t5_align_err", {31'd0, align_err}, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, rand_data(), "t5_hunt_data");
    send_lock();
    chk("t5_relock", {31'd0, active}, 32'd1);

    // 6: reset mid-word
    step(1'b1, 8'hA1, "t6"); step(1'b1, 8'hA2, "t6");
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_reset");
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset_L = 1'b1;
    step(1'b1, 8'hA3, "t6_after"); step(1'b1, 8'hA4, "t6_after");
    chk("t6_no_word", {31'd0, word_valid}, 32'd0);

    // Random traffic: COM bursts, data with IDL/COM/valid gaps, occasional loss bursts.
    for (int r = 0; r < 120; r++) begin
      int kind = $urandom_range(0, 9);
      if (kind < 3) begin
        int n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) step(1'b1, 8'hBC, "rnd_com");
      end else if (kind < 5) begin
        int n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), "rnd_gap");
      end else begin
        int n = $urandom_range(4, 20);
        for (int i = 0; i < n; i++) begin
          int p = $urandom_range(0, 99);
          if (p < 5)       step(1'b1, 8'hBC, "rnd_com1");
          else if (p < 15) step(1'b1, 8'h7C, "rnd_idl");
          else if (p < 22) step(1'b0, 8'h00, "rnd_inv");
          else             step(1'b1, rand_data(), "rnd_data");
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
